// File: rtl/bitstream_write_buffer_if.sv
// Handshake bundle between the bit-packer, the write buffer and the memory sink.
// The master side drives the packer inputs and the sink's wr_ready.
interface bitstream_write_buffer_if;
  logic         start;
  logic [31:0]  base_addr;
  logic         in_valid;
  logic [127:0] in_data;
  logic         flush;
  logic [127:0] res_data;
  logic [7:0]   res_len;
  logic         afull;
  logic         wr_valid;
  logic [31:0]  wr_addr;
  logic [127:0] wr_data;
  logic         wr_ready;
  logic         done;
  logic [31:0]  total_bits;
  logic         overflow;

  modport master (
    output start, base_addr, in_valid, in_data, flush, res_data, res_len, wr_ready,
    input  afull, wr_valid, wr_addr, wr_data, done, total_bits, overflow
  );

  modport slave (
    input  start, base_addr, in_valid, in_data, flush, res_data, res_len, wr_ready,
    output afull, wr_valid, wr_addr, wr_data, done, total_bits, overflow
  );
endinterface

// File: rtl/bitstream_write_buffer.sv
// Buffers packed 128-bit words from the bit shifter, appends a left-aligned pad word on
// flush, and streams everything to a valid/ready sink at consecutive word addresses.
module bitstream_write_buffer #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AFULL = 12
) (
  input logic                     clk,
  input logic                     reset,
  bitstream_write_buffer_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StRun   = 3'd1;
  localparam logic [2:0] StFlush = 3'd2;
  localparam logic [2:0] StDrain = 3'd3;
  localparam logic [2:0] StDone  = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [127:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] fifo_cnt_q, occ;
  logic          wr_valid_q;
  logic [31:0]   wr_addr_q;
  logic [127:0]  wr_data_q;
  logic [31:0]   word_cnt_q, total_bits_q;
  logic          overflow_q;
  logic [127:0]  res_data_q;
  logic [7:0]    res_len_q;

  logic         hs, load, pop, full, can_push, run_push, pad_push, push, drop, start_ok;
  logic [127:0] push_data;

  // Occupancy includes the word parked in the output register, so the full
  // capacity (FIFO plus output stage) is exactly DEPTH words.
  always_comb begin
    hs        = wr_valid_q & bus.wr_ready;
    load      = ~wr_valid_q | bus.wr_ready;
    pop       = load & (fifo_cnt_q != '0);
    occ       = fifo_cnt_q + CW'(wr_valid_q);
    full      = (occ == CW'(DEPTH));
    can_push  = ~full | hs;
    start_ok  = (state_q == StIdle) & bus.start;
    run_push  = (state_q == StRun) & bus.in_valid & can_push;
    drop      = (state_q == StRun) & bus.in_valid & ~can_push;
    pad_push  = (state_q == StFlush) & (res_len_q != '0) & can_push;
    push      = run_push | pad_push;
    push_data = run_push ? bus.in_data : (res_data_q << (8'd128 - res_len_q));
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (bus.start) state_d = StRun;
      StRun:   if (bus.flush) state_d = StFlush;
      StFlush: if ((res_len_q == '0) || can_push) state_d = StDrain;
      StDrain: if ((fifo_cnt_q == '0) && !wr_valid_q) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      wptr_q       <= '0;
      rptr_q       <= '0;
      fifo_cnt_q   <= '0;
      wr_valid_q   <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      word_cnt_q   <= '0;
      total_bits_q <= '0;
      overflow_q   <= 1'b0;
      res_data_q   <= '0;
      res_len_q    <= '0;
    end else begin
      state_q    <= state_d;
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      fifo_cnt_q <= fifo_cnt_q + CW'(push) - CW'(pop);

      if (load) begin
        wr_valid_q <= pop;
        if (pop) wr_data_q <= mem_q[rptr_q];
      end

      if (start_ok)  wr_addr_q <= bus.base_addr;
      else if (hs)   wr_addr_q <= wr_addr_q + 32'd1;

      if (start_ok)      word_cnt_q <= '0;
      else if (run_push) word_cnt_q <= word_cnt_q + 32'd1;

      if (start_ok)  overflow_q <= 1'b0;
      else if (drop) overflow_q <= 1'b1;

      if ((state_q == StRun) && bus.flush) begin
        res_data_q <= bus.res_data;
        res_len_q  <= bus.res_len;
      end

      if (start_ok) total_bits_q <= '0;
      else if ((state_q == StDrain) && (state_d == StDone))
        total_bits_q <= (word_cnt_q << 7) + {24'd0, res_len_q};
    end
  end

  assign bus.afull      = (occ >= CW'(AFULL));
  assign bus.wr_valid   = wr_valid_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.done       = (state_q == StDone);
  assign bus.total_bits = total_bits_q;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_bitstream_write_buffer.sv
// Directed bench for bitstream_write_buffer: drives after posedge+1, samples at negedge.
module tb_bitstream_write_buffer;
  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass = 0;

  logic [127:0] wq_data[$];
  logic [31:0]  wq_addr[$];
  int           stall_viol = 0;
  logic         prev_stall = 1'b0;
  logic [127:0] prev_data;
  logic [31:0]  prev_addr;

  bitstream_write_buffer_if bus ();

  bitstream_write_buffer #(.DEPTH(16), .AFULL(12)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Logs every handshake and flags any change of the output while stalled.
  always @(negedge clk) begin
    if (reset !== 1'b0) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (bus.wr_valid !== 1'b1 || bus.wr_data !== prev_data ||
                         bus.wr_addr !== prev_addr))
        stall_viol++;
      if (bus.wr_valid === 1'b1 && bus.wr_ready === 1'b1) begin
        wq_data.push_back(bus.wr_data);
        wq_addr.push_back(bus.wr_addr);
      end
      prev_stall = (bus.wr_valid === 1'b1) && (bus.wr_ready === 1'b0);
      prev_data  = bus.wr_data;
      prev_addr  = bus.wr_addr;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [31:0] addr);
    wq_data.delete();
    wq_addr.delete();
    bus.base_addr = addr;
    bus.start     = 1'b1;
    tick();
    bus.start     = 1'b0;
  endtask

  task automatic push_word(input logic [127:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic do_flush(input logic [127:0] rd, input logic [7:0] rl, input logic with_word,
                          input logic [127:0] d);
    bus.flush    = 1'b1;
    bus.res_data = rd;
    bus.res_len  = rl;
    bus.in_valid = with_word;
    bus.in_data  = d;
    tick();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
  endtask

  function automatic logic [127:0] stall_word(input int i);
    return {32'hCAFE_0000 | 32'(i), 64'h0123_4567_89AB_CDEF, 32'(i)};
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b1;
    bus.base_addr = 32'hDEAD_BEEF;
    bus.in_valid = 1'b1;
    bus.in_data = '1;
    repeat (3) tick();
    n_checks++;
    if (bus.wr_valid !== 1'b0) $display("FAIL reset_wr_valid: got %b want 0", bus.wr_valid);
    else n_pass++;
    n_checks++;
    if (bus.wr_addr !== 32'h0) $display("FAIL reset_wr_addr: got %h want 0", bus.wr_addr);
    else n_pass++;
    n_checks++;
    if (bus.wr_data !== 128'h0) $display("FAIL reset_wr_data: got %h want 0", bus.wr_data);
    else n_pass++;
    n_checks++;
    if ({bus.done, bus.afull, bus.overflow} !== 3'b000)
      $display("FAIL reset_flags: got done/afull/ovf %b want 000",
               {bus.done, bus.afull, bus.overflow});
    else n_pass++;
    n_checks++;
    if (bus.total_bits !== 32'h0) $display("FAIL reset_total: got %0d want 0", bus.total_bits);
    else n_pass++;
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [127:0] exp_d [3];
    bit seen;
    exp_d[0] = 128'hAAAA_0000_1111_2222_3333_4444_5555_6666;
    exp_d[1] = 128'hBBBB_7777_8888_9999_AAAA_BBBB_CCCC_DDDD;
    exp_d[2] = 128'hCCCC_0123_4567_89AB_CDEF_FEDC_BA98_7654;
    do_start(32'h100);
    for (int i = 0; i < 3; i++) push_word(exp_d[i]);
    do_flush('0, 8'd0, 1'b0, '0);
    wait_done(100, seen);
    n_checks++;
    if (seen !== 1'b1) $display("FAIL basic_done: got no done want done pulse");
    else n_pass++;
    n_checks++;
    if (wq_data.size() !== 3) $display("FAIL basic_count: got %0d want 3", wq_data.size());
    else n_pass++;
    for (int i = 0; i < 3 && i < wq_data.size(); i++) begin
      n_checks++;
      if (wq_data[i] !== exp_d[i] || wq_addr[i] !== 32'h100 + 32'(i))
        $display("FAIL basic_write%0d: got %h@%h want %h@%h", i, wq_data[i], wq_addr[i],
                 exp_d[i], 32'h100 + 32'(i));
      else n_pass++;
    end
    n_checks++;
    if (bus.total_bits !== 32'd384) $display("FAIL basic_total: got %0d want 384", bus.total_bits);
    else n_pass++;
    tick();
    n_checks++;
    if (bus.done !== 1'b0) $display("FAIL basic_done_width: got %b want 0", bus.done);
    else n_pass++;
    n_checks++;
    if (bus.total_bits !== 32'd384) $display("FAIL basic_total_hold: got %0d want 384",
                                             bus.total_bits);
    else n_pass++;
  endtask

  task automatic test_pad();
    bit seen;
    do_start(32'h200);
    push_word(128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321);
    do_flush(128'h5, 8'd3, 1'b0, '0);
    wait_done(100, seen);
    n_checks++;
    if (seen !== 1'b1 || wq_data.size() !== 2)
      $display("FAIL pad_count: got done=%b writes=%0d want done=1 writes=2", seen, wq_data.size());
    else n_pass++;
    if (wq_data.size() == 2) begin
      n_checks++;
      if (wq_data[1] !== 128'hA000_0000_0000_0000_0000_0000_0000_0000 || wq_addr[1] !== 32'h201)
        $display("FAIL pad_word: got %h@%h want a000..0@00000201", wq_data[1], wq_addr[1]);
      else n_pass++;
    end
    n_checks++;
    if (bus.total_bits !== 32'd131) $display("FAIL pad_total: got %0d want 131", bus.total_bits);
    else n_pass++;
    tick();
  endtask

  task automatic test_backpressure();
    bit seen;
    bus.wr_ready = 1'b0;
    do_start(32'h300);
    for (int k = 1; k <= 16; k++) begin
      push_word(128'(k) | 128'hB000_0000_0000_0000_0000_0000_0000_0000);
      n_checks++;
      if (bus.afull !== (k >= 12))
        $display("FAIL bp_afull_after_%0d: got %b want %b", k, bus.afull, (k >= 12));
      else n_pass++;
    end
    n_checks++;
    if (bus.overflow !== 1'b0) $display("FAIL bp_no_overflow_at_16: got %b want 0", bus.overflow);
    else n_pass++;
    push_word(128'hDEAD);
    n_checks++;
    if (bus.overflow !== 1'b1) $display("FAIL bp_overflow: got %b want 1", bus.overflow);
    else n_pass++;
    do_flush('0, 8'd0, 1'b0, '0);
    bus.wr_ready = 1'b1;
    wait_done(200, seen);
    n_checks++;
    if (seen !== 1'b1 || wq_data.size() !== 16)
      $display("FAIL bp_count: got done=%b writes=%0d want done=1 writes=16", seen, wq_data.size());
    else n_pass++;
    for (int i = 0; i < 16 && i < wq_data.size(); i++) begin
      n_checks++;
      if (wq_data[i] !== (128'(i + 1) | 128'hB000_0000_0000_0000_0000_0000_0000_0000) ||
          wq_addr[i] !== 32'h300 + 32'(i))
        $display("FAIL bp_write%0d: got %h@%h want word %0d@%h", i, wq_data[i], wq_addr[i],
                 i + 1, 32'h300 + 32'(i));
      else n_pass++;
    end
    n_checks++;
    if (bus.total_bits !== 32'd2048 || bus.overflow !== 1'b1)
      $display("FAIL bp_total: got %0d ovf=%b want 2048 ovf=1", bus.total_bits, bus.overflow);
    else n_pass++;
    tick();
  endtask

  task automatic test_same_cycle_flush();
    bit seen;
    do_start(32'h400);
    push_word(128'h11);
    push_word(128'h22);
    do_flush({64'hFFFF_FFFF_FFFF_FFFF, 64'h0123_4567_89AB_CDEF}, 8'd64, 1'b1, 128'h33);
    wait_done(100, seen);
    n_checks++;
    if (seen !== 1'b1 || wq_data.size() !== 4)
      $display("FAIL same_count: got done=%b writes=%0d want done=1 writes=4", seen, wq_data.size());
    else n_pass++;
    if (wq_data.size() == 4) begin
      n_checks++;
      if (wq_data[2] !== 128'h33 || wq_data[3] !== {64'h0123_4567_89AB_CDEF, 64'h0} ||
          wq_addr[3] !== 32'h403)
        $display("FAIL same_order: got %h,%h@%h want 33,0123456789abcdef0..0@403",
                 wq_data[2], wq_data[3], wq_addr[3]);
      else n_pass++;
    end
    n_checks++;
    if (bus.total_bits !== 32'd448) $display("FAIL same_total: got %0d want 448", bus.total_bits);
    else n_pass++;
    tick();
  endtask

  task automatic test_stall();
    bit seen;
    int sent;
    int guard;
    int bad;
    stall_viol = 0;
    do_start(32'hFFFF_FFF0);
    sent = 0;
    guard = 0;
    while (sent < 100 && guard < 3000) begin
      bus.wr_ready = 1'($urandom_range(0, 1));
      if (bus.afull === 1'b0) begin
        bus.in_valid = 1'b1;
        bus.in_data  = stall_word(sent);
        sent++;
      end else begin
        bus.in_valid = 1'b0;
      end
      tick();
      guard++;
    end
    bus.in_valid = 1'b0;
    n_checks++;
    if (sent !== 100) $display("FAIL stall_sent: got %0d want 100", sent);
    else n_pass++;
    do_flush('0, 8'd0, 1'b0, '0);
    seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      bus.wr_ready = 1'($urandom_range(0, 1));
      tick();
    end
    bus.wr_ready = 1'b1;
    n_checks++;
    if (seen !== 1'b1 || wq_data.size() !== 100)
      $display("FAIL stall_count: got done=%b writes=%0d want done=1 writes=100",
               seen, wq_data.size());
    else n_pass++;
    bad = 0;
    for (int i = 0; i < 100 && i < wq_data.size(); i++)
      if (wq_data[i] !== stall_word(i) || wq_addr[i] !== 32'hFFFF_FFF0 + 32'(i)) bad++;
    n_checks++;
    if (bad !== 0) $display("FAIL stall_order: got %0d bad writes want 0", bad);
    else n_pass++;
    n_checks++;
    if (stall_viol !== 0) $display("FAIL stall_stable: got %0d changes want 0", stall_viol);
    else n_pass++;
    n_checks++;
    if (bus.total_bits !== 32'd12800 || bus.overflow !== 1'b0)
      $display("FAIL stall_total: got %0d ovf=%b want 12800 ovf=0", bus.total_bits, bus.overflow);
    else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid_stream();
    bit seen;
    bit stray;
    bus.wr_ready = 1'b0;
    do_start(32'h500);
    for (int i = 0; i < 5; i++) push_word(128'h5500 + 128'(i));
    tick();
    n_checks++;
    if (bus.wr_valid !== 1'b1) $display("FAIL mid_pre_valid: got %b want 1", bus.wr_valid);
    else n_pass++;
    reset = 1'b1;
    tick();
    n_checks++;
    if (bus.wr_valid !== 1'b0 || bus.wr_addr !== 32'h0 || bus.afull !== 1'b0)
      $display("FAIL mid_reset: got valid=%b addr=%h afull=%b want 0/0/0",
               bus.wr_valid, bus.wr_addr, bus.afull);
    else n_pass++;
    reset = 1'b0;
    bus.wr_ready = 1'b1;
    // In IDLE: in_valid and flush must be ignored.
    bus.in_valid = 1'b1;
    bus.in_data  = 128'hBAD;
    bus.flush    = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    stray = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (bus.done !== 1'b0 || bus.wr_valid !== 1'b0 || bus.overflow !== 1'b0) stray = 1'b1;
      tick();
    end
    n_checks++;
    if (stray !== 1'b0) $display("FAIL idle_ignore: got activity=1 want 0");
    else n_pass++;
    do_start(32'h600);
    push_word(128'h61);
    push_word(128'h62);
    do_flush('0, 8'd0, 1'b0, '0);
    wait_done(100, seen);
    n_checks++;
    if (seen !== 1'b1 || wq_data.size() !== 2)
      $display("FAIL mid_restart_count: got done=%b writes=%0d want done=1 writes=2",
               seen, wq_data.size());
    else n_pass++;
    if (wq_data.size() == 2) begin
      n_checks++;
      if (wq_data[0] !== 128'h61 || wq_addr[0] !== 32'h600 ||
          wq_data[1] !== 128'h62 || wq_addr[1] !== 32'h601)
        $display("FAIL mid_restart_writes: got %h@%h,%h@%h want 61@600,62@601",
                 wq_data[0], wq_addr[0], wq_data[1], wq_addr[1]);
      else n_pass++;
    end
    n_checks++;
    if (bus.total_bits !== 32'd256) $display("FAIL mid_total: got %0d want 256", bus.total_bits);
    else n_pass++;
    tick();
  endtask

  initial begin
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.base_addr = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.flush     = 1'b0;
    bus.res_data  = '0;
    bus.res_len   = '0;
    bus.wr_ready  = 1'b1;
    test_reset();
    test_basic();
    test_pad();
    test_backpressure();
    test_same_cycle_flush();
    test_stall();
    test_reset_mid_stream();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/bitstream_write_buffer.md
BITSTREAM_WRITE_BUFFER -- requirements
Module: bitstream_write_buffer

Interface
REQ-001 Parameter DEPTH, default 16: FIFO depth in 128-bit words; power of two, minimum 4.
REQ-002 Parameter AFULL, default 12: occupancy at or above which afull asserts.
REQ-003 Ports (name, direction, width, meaning), clock and reset first, are listed below.
- clk, input, 1: clock; all logic rising-edge.
- reset, input, 1: synchronous, active-high.
- start, input, 1: pulse; latches base_addr and clears counters.
- base_addr, input, 32: first write word address.
- in_valid, input, 1: in_data holds a completed packed word (the shifter's data_full).
- in_data, input, 128: packed word (the shifter's data_to_write).
- flush, input, 1: pulse marking end of stream.
- res_data, input, 128: pending residual bits at LSB (the shifter's data_out[127:0]).
- res_len, input, 8: residual bit count, 0..127 (the shifter's current_len).
- afull, output, 1: backpressure; upstream deasserts the shifter enable.
- wr_valid, output, 1: write request.
- wr_addr, output, 32: word address.
- wr_data, output, 128: write data.
- wr_ready, input, 1: sink accepts when wr_valid and wr_ready are both high.
- done, output, 1: one-cycle pulse; stream fully written.
- total_bits, output, 32: stream length in bits.
- overflow, output, 1: sticky; a word was dropped.

Function
REQ-004 States: IDLE, RUN, FLUSH, DRAIN, DONE; reset enters IDLE.
REQ-005 IDLE: start moves to RUN next cycle; wr_addr is loaded with base_addr; word_cnt, total_bits and overflow are cleared.
REQ-006 RUN: in_valid pushes in_data into the FIFO; word_cnt increments by 1 per pushed word.
REQ-007 in_valid outside RUN is ignored and is not flagged.
REQ-008 in_valid with the FIFO holding DEPTH words drops the word and sets overflow; word_cnt does not increment.
REQ-009 RUN plus flush moves to FLUSH and captures res_data and res_len.
- If in_valid is also high in that cycle, in_data is pushed in that same cycle.
REQ-010 FLUSH, res_len nonzero: push one pad word, (res_data << (128 - res_len)) truncated to 128 bits, zero-filled below.
- The push waits in FLUSH while the FIFO is full; it never drops.
- After the push, move to DRAIN.
REQ-011 FLUSH, res_len zero: no pad word is pushed; move to DRAIN the next cycle.
REQ-012 DRAIN: exit to DONE when the FIFO is empty and wr_valid is low.
REQ-013 DONE: assert done for exactly one cycle, then return to IDLE.
- total_bits = 128*word_cnt + captured res_len, computed in 32 bits.
- The pad word is not counted in word_cnt.
- total_bits holds its value until the next start.
REQ-014 The output register loads from the FIFO head when wr_valid is low or a handshake occurs; a FIFO word reaches wr_valid at the earliest 1 cycle after its push.
REQ-015 Output stability: while wr_valid is high and wr_ready is low, wr_data and wr_addr hold stable.
REQ-016 Address advance: wr_addr increments by 1 on each handshake and wraps modulo 2^32.
REQ-017 Back-to-back: with wr_ready held high, throughput is one word per cycle and there is no bubble between FIFO words.
REQ-018 Occupancy: push and pop in the same cycle leave occupancy unchanged; this holds when the FIFO is full and also when it is empty.
REQ-019 afull is high while occupancy >= AFULL, in all states.
REQ-020 start is ignored outside IDLE; flush is ignored outside RUN.

Reset
REQ-021 reset has priority over all inputs and takes effect on the next edge, including mid-stream and mid-handshake.
REQ-022 Reset values: state IDLE, FIFO empty, wr_valid 0, wr_addr 0, wr_data 0, done 0, afull 0, overflow 0, total_bits 0.

Verification
REQ-023 Basic stream: base_addr 0x100, start, then 3 in_valid words A, B, C, then flush with res_len 0.
- Required: writes A, B, C at addresses 0x100, 0x101, 0x102.
- Required: done pulse, total_bits 384.
REQ-024 Pad word: 1 word, then flush with res_data 0x5 and res_len 3.
- Required: second write data = 0xA000...0 (bits 127:125 = 101).
- Required: total_bits 131.
REQ-025 Backpressure: wr_ready low, 16 words pushed, then a 17th in_valid.
- Required: afull high from the 12th word.
- Required: 17th word dropped and overflow set.
- Required: after wr_ready rises, 16 writes occur in order.
REQ-026 Same-cycle flush: in_valid and flush in the same cycle, res_len 64.
- Required: in_data is written before the pad word.
- Required: total_bits = 128*N + 64.
REQ-027 Stall: wr_ready toggled randomly for 100 words.
- Required: wr_data and wr_addr stable during every stall.
- Required: no duplicated or lost words.
REQ-028 Reset mid-stream: reset asserted with 5 words queued and wr_valid high.
- Required: next cycle wr_valid 0 and state IDLE.
- Required: a subsequent start runs cleanly from the new base_addr.
